// File: rtl/io_pkg.sv
// Shared constants for the UART/CPU byte buffer:
// status bit positions, TX FSM states and the default FIFO depth.
package io_pkg;

   localparam int IO_ERR_RX_OVF  = 0;
   localparam int IO_ERR_FRAME   = 1;
   localparam int IO_ERR_RX_FULL = 2;
   localparam int IO_ERR_TX_FULL = 3;

   localparam int IO_DEPTH_LOG2 = 4;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_HOLD = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_e;

endpackage

// File: rtl/io_buffer_if.sv
// CPU-side IO port: io_in/io_out valid/ready channels plus status.
// master = CPU, slave = io_buffer.
interface io_buffer_if;

   logic [7:0] io_in_data;
   logic       io_in_vld;
   logic       io_in_rdy;
   logic [7:0] io_out_data;
   logic       io_out_vld;
   logic       io_out_rdy;
   logic [4:0] io_err;
   logic       err_clr;

   modport master (
      input  io_in_data, io_in_vld,
      output io_in_rdy,
      output io_out_data, io_out_vld,
      input  io_out_rdy,
      input  io_err,
      output err_clr
   );

   modport slave (
      output io_in_data, io_in_vld,
      input  io_in_rdy,
      input  io_out_data, io_out_vld,
      output io_out_rdy,
      output io_err,
      input  err_clr
   );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO with asynchronous reset.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [7:0]          wdata,
   output logic [7:0]          rdata,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop) count <= count + CNT_ONE;
         else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/io_buffer.sv
// Byte buffer between UART and CPU IO port: RX FIFO to io_in,
// io_out to TX FIFO drained into the UART by a three-state FSM.
module io_buffer
   import io_pkg::*;
#(
   parameter int DEPTH_LOG2 = IO_DEPTH_LOG2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_frame_err,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   io_buffer_if.slave cpu
);

   localparam logic [DEPTH_LOG2:0] FULL_CNT =
      (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

   logic [7:0]          rx_head, tx_head;
   logic                rx_full, rx_empty;
   logic                tx_full, tx_empty;
   logic [DEPTH_LOG2:0] rx_count, tx_count;
   logic                rx_pop, rx_ovf;
   logic                tx_push, tx_pop;
   logic                start_nxt;
   logic [1:0]          err_q;
   logic [4:0]          err_w;
   tx_state_e           state, state_nxt;

   assign rx_pop  = cpu.io_in_rdy & ~rx_empty;
   assign rx_ovf  = rx_valid & rx_full & ~rx_pop;
   assign tx_push = cpu.io_out_vld & ~tx_full;

   sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
      .clk(clk), .rst(rst),
      .push(rx_valid), .pop(rx_pop),
      .wdata(rx_data), .rdata(rx_head),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
      .clk(clk), .rst(rst),
      .push(tx_push), .pop(tx_pop),
      .wdata(cpu.io_out_data), .rdata(tx_head),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   assign cpu.io_in_data = rx_head;
   assign cpu.io_in_vld  = ~rx_empty;
   assign cpu.io_out_rdy = ~tx_full;

   // HOLD ignores tx_busy: the UART raises busy one cycle after tx_start
   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      start_nxt = 1'b0;
      unique case (state)
         TX_IDLE: if (!tx_empty && !tx_busy) begin
            tx_pop    = 1'b1;
            start_nxt = 1'b1;
            state_nxt = TX_HOLD;
         end
         TX_HOLD: state_nxt = TX_WAIT;
         TX_WAIT: if (!tx_busy) state_nxt = TX_IDLE;
         default: state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= TX_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= state_nxt;
         tx_start <= start_nxt;
         if (tx_pop) tx_data <= tx_head;
      end
   end

   // a new error event wins over a coincident clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         if (rx_ovf) err_q[0] <= 1'b1;
         else if (cpu.err_clr) err_q[0] <= 1'b0;
         if (rx_frame_err) err_q[1] <= 1'b1;
         else if (cpu.err_clr) err_q[1] <= 1'b0;
      end
   end

   always_comb begin
      err_w                 = '0;
      err_w[IO_ERR_RX_OVF]  = err_q[0];
      err_w[IO_ERR_FRAME]   = err_q[1];
      err_w[IO_ERR_RX_FULL] = (rx_count == FULL_CNT);
      err_w[IO_ERR_TX_FULL] = (tx_count == FULL_CNT);
   end

   assign cpu.io_err = err_w;

endmodule

// File: tb/tb_io_buffer.sv
// Directed plus randomized bench for io_buffer against a queue-based
// model of the RX/TX FIFOs, status bits and transmit pacing.
module tb_io_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   io_buffer_if bus ();

   io_buffer dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err),
      .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy),
      .cpu(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [7:0] sent[$];
   int         sent_cyc[$];
   bit         m_ovf, m_fe, m_start;
   logic [7:0] m_txd;
   int         m_phase;

   bit uart_auto = 0;
   bit pend = 0;
   int busy_left = 0;
   int blen = 10;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rxq.delete();
      txq.delete();
      m_ovf = 0; m_fe = 0; m_start = 0;
      m_txd = 8'h00; m_phase = 0;
   endtask

   // one rising edge of the reference behaviour, using current inputs
   task automatic model_edge();
      int  rn = rxq.size();
      int  tn = txq.size();
      bit  rpop = bus.io_in_rdy && rn > 0;
      bit  oset = rx_valid && rn == 16 && !rpop;
      bit  tpush = bus.io_out_vld && tn < 16;
      if (rpop) void'(rxq.pop_front());
      if (rx_valid && !oset) rxq.push_back(rx_data);
      m_ovf = oset ? 1'b1 : (bus.err_clr ? 1'b0 : m_ovf);
      m_fe = rx_frame_err ? 1'b1 : (bus.err_clr ? 1'b0 : m_fe);
      m_start = 0;
      case (m_phase)
         0: if (tn > 0 && !tx_busy) begin
            m_txd = txq.pop_front();
            m_start = 1;
            m_phase = 1;
            sent.push_back(m_txd);
            sent_cyc.push_back(cyc + 1);
         end
         1: m_phase = 2;
         default: if (!tx_busy) m_phase = 0;
      endcase
      if (tpush) txq.push_back(bus.io_out_data);
   endtask

   task automatic check_all();
      chk("io_in_vld", bus.io_in_vld, rxq.size() > 0);
      if (rxq.size() > 0) chk("io_in_data", bus.io_in_data, rxq[0]);
      chk("io_out_rdy", bus.io_out_rdy, txq.size() < 16);
      chk("io_err", bus.io_err,
          {1'b0, txq.size() == 16, rxq.size() == 16, m_fe, m_ovf});
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_txd);
   endtask

   // UART stand-in: busy rises one cycle after tx_start, holds blen cycles
   task automatic uart();
      if (!uart_auto) return;
      if (pend) begin
         busy_left = blen;
         pend = 0;
      end
      if (m_start) pend = 1;
      tx_busy = busy_left > 0;
      if (busy_left > 0) busy_left--;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
      uart();
   endtask

   task automatic idle_inputs();
      rx_valid = 0; rx_frame_err = 0; rx_data = 8'h00;
      bus.io_in_rdy = 0; bus.io_out_vld = 0;
      bus.io_out_data = 8'h00; bus.err_clr = 0;
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_tx_data"}, tx_data, 8'h00);
      chk({tag, "_tx_start"}, tx_start, 1'b0);
      chk({tag, "_in_vld"}, bus.io_in_vld, 1'b0);
      chk({tag, "_in_data"}, bus.io_in_data, 8'h00);
      chk({tag, "_out_rdy"}, bus.io_out_rdy, 1'b1);
      chk({tag, "_err"}, bus.io_err, 5'b00000);
   endtask

   // asynchronous reset asserted between edges, checked before any edge
   task automatic async_reset(string tag);
      idle_inputs();
      #2;
      rst = 1;
      #1;
      check_reset_vals(tag);
      model_reset();
      pend = 0; busy_left = 0; tx_busy = 0;
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      int n;
      idle_inputs();
      tx_busy = 0;
      rst = 1;
      #12;
      check_reset_vals("por");
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      step();

      // RX ordering
      for (int i = 0; i < 3; i++) begin
         rx_data = 8'h41 + 8'(i); rx_valid = 1; step();
      end
      rx_valid = 0;
      bus.io_in_rdy = 1;
      for (int i = 0; i < 3; i++) begin
         chk("rx_order", bus.io_in_data, 8'h41 + 8'(i));
         step();
      end
      chk("rx_order_empty", bus.io_in_vld, 1'b0);
      bus.io_in_rdy = 0;

      // RX overflow
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'(i); rx_valid = 1; step();
      end
      rx_valid = 0;
      chk("ovf_err", bus.io_err, 5'b00101);
      bus.io_in_rdy = 1;
      for (int i = 0; i < 16; i++) begin
         chk("ovf_read", bus.io_in_data, 8'(i));
         step();
      end
      bus.io_in_rdy = 0;
      chk("ovf_drained", bus.io_in_vld, 1'b0);
      chk("ovf_sticky", bus.io_err, 5'b00001);
      bus.err_clr = 1; step(); bus.err_clr = 0;
      chk("ovf_clr", bus.io_err, 5'b00000);

      // TX handshake with 10-cycle busy
      sent.delete(); sent_cyc.delete();
      uart_auto = 1; blen = 10;
      bus.io_out_vld = 1; bus.io_out_data = 8'h55; step();
      bus.io_out_data = 8'hAA; step();
      bus.io_out_vld = 0;
      repeat (40) step();
      chk("tx_hs_count", sent.size(), 2);
      if (sent.size() == 2) begin
         chk("tx_hs_first", sent[0], 8'h55);
         chk("tx_hs_second", sent[1], 8'hAA);
         chk("tx_hs_spacing", sent_cyc[1] - sent_cyc[0], 13);
      end

      // TX full with busy stuck high
      uart_auto = 0; tx_busy = 1;
      sent.delete(); sent_cyc.delete();
      bus.io_out_vld = 1;
      for (int i = 0; i < 16; i++) begin
         bus.io_out_data = 8'h10 + 8'(i); step();
      end
      chk("tx_full_rdy", bus.io_out_rdy, 1'b0);
      chk("tx_full_err", bus.io_err[3], 1'b1);
      bus.io_out_data = 8'h77;
      repeat (3) step();
      chk("tx_full_hold", bus.io_out_rdy, 1'b0);
      tx_busy = 0; uart_auto = 1; blen = 2;
      step();
      chk("tx_full_reopen", bus.io_out_rdy, 1'b1);
      step();
      bus.io_out_vld = 0;
      repeat (100) step();
      chk("tx_full_sent", sent.size(), 17);
      if (sent.size() == 17) chk("tx_full_last", sent[16], 8'h77);

      // RX full with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         rx_data = 8'($urandom); rx_valid = 1; step();
      end
      rx_data = 8'hEE; bus.io_in_rdy = 1; step();
      rx_valid = 0;
      chk("simul_err", bus.io_err, 5'b00100);
      n = 0;
      while (bus.io_in_vld && n < 20) begin
         step(); n++;
      end
      bus.io_in_rdy = 0;
      chk("simul_count", n, 16);

      // asynchronous reset with both FIFOs loaded mid-transfer
      uart_auto = 1; blen = 6;
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'hC0 + 8'(i); rx_valid = 1;
         bus.io_out_data = 8'hD0 + 8'(i); bus.io_out_vld = 1;
         step();
      end
      async_reset("mid");
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rx_valid = ($urandom_range(2) == 0);
         rx_data = 8'($urandom);
         rx_frame_err = ($urandom_range(19) == 0);
         bus.err_clr = ($urandom_range(15) == 0);
         bus.io_in_rdy = ($urandom_range(2) == 0);
         bus.io_out_vld = ($urandom_range(1) == 0);
         bus.io_out_data = 8'($urandom);
         blen = $urandom_range(1, 5);
         step();
         if (i == 1500) async_reset("rnd");
      end
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
